// File: rtl/cpu_pkg.sv
// Shared opcodes, IR field positions, sequencer states and strobe bundle for the hardwired control unit.
package cpu_pkg;

   localparam int REG_W  = 4;
   localparam int OP_MSB = 31;
   localparam int OP_LSB = 27;
   localparam int RA_LSB = 23;
   localparam int RB_LSB = 19;
   localparam int RC_LSB = 15;
   localparam int C_MSB  = 18;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_SHRA = 5'b01010;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_MUL  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;
   localparam logic [4:0] ALU_ADD = OP_ADD;

   typedef enum logic [3:0] {
      S_RESET = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
      S_T4    = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd9
   } state_t;

   typedef enum logic [3:0] {
      CL_ALU = 4'd0, CL_IMM = 4'd1, CL_UNARY = 4'd2, CL_MULDIV = 4'd3, CL_LD = 4'd4,
      CL_LDI = 4'd5, CL_ST = 4'd6, CL_NOP = 4'd7, CL_HALT = 4'd8
   } op_class_t;

   typedef struct packed {
      logic hi_in, hi_out, lo_in, lo_out, z_in, zhigh_out, zlow_out, y_in;
      logic mdr_in, mdr_out, mar_in, pc_in, pc_out, ir_in, inc_pc, c_out, rd, wr;
   } strobe_t;

   // Undefined opcodes fall into CL_NOP so they execute as nop.
   function automatic op_class_t classify(input logic [4:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
         OP_ROL, OP_SHR, OP_SHRA, OP_SHL:  return CL_ALU;
         OP_ADDI, OP_ANDI, OP_ORI:         return CL_IMM;
         OP_NEG, OP_NOT:                   return CL_UNARY;
         OP_MUL, OP_DIV:                   return CL_MULDIV;
         OP_LD:                            return CL_LD;
         OP_LDI:                           return CL_LDI;
         OP_ST:                            return CL_ST;
         OP_HALT:                          return CL_HALT;
         default:                          return CL_NOP;
      endcase
   endfunction

endpackage

// File: rtl/reg_select_decode.sv
// Turns the Ra/Rb/Rc field picked by gra/grb/grc into one-hot register load and bus-drive selects.
module reg_select_decode
   import cpu_pkg::*;
#(
   parameter int NUM_REGS = 16
) (
   input  logic [REG_W-1:0]    ra,
   input  logic [REG_W-1:0]    rb,
   input  logic [REG_W-1:0]    rc,
   input  logic                gra,
   input  logic                grb,
   input  logic                grc,
   input  logic                rin_en,
   input  logic                rout_en,
   output logic [NUM_REGS-1:0] rin,
   output logic [NUM_REGS-1:0] rout
);

   logic [REG_W-1:0] sel_s;

   // Field mux and one-hot expansion.
   always_comb begin
      sel_s = ({REG_W{gra}} & ra) | ({REG_W{grb}} & rb) | ({REG_W{grc}} & rc);
      rin   = '0;
      rout  = '0;
      if (rin_en) begin
         rin[sel_s] = 1'b1;
      end else begin
         rin = '0;
      end
      if (rout_en) begin
         rout[sel_s] = 1'b1;
      end else begin
         rout = '0;
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer driving every DataPath strobe as a Moore function of state and IR.
// Optional macro CTRL_SINGLE_STEP_EN adds a `step` input that gates T0 to one instruction per rising edge.
module control_sequencer
   import cpu_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int OP_W     = 5
) (
   input  logic                clock,
   input  logic                clear,
   input  logic [31:0]         ir,
   input  logic                mem_ready,
   input  logic                stop,
`ifdef CTRL_SINGLE_STEP_EN
   input  logic                step,
`endif
   output logic                run,
   output logic [NUM_REGS-1:0] rin,
   output logic [NUM_REGS-1:0] rout,
   output logic                HIin,
   output logic                HIout,
   output logic                LOin,
   output logic                LOout,
   output logic                Zin,
   output logic                Zhighout,
   output logic                Zlowout,
   output logic                Yin,
   output logic                MDRin,
   output logic                MDRout,
   output logic                MARin,
   output logic                PCin,
   output logic                PCout,
   output logic                IRin,
   output logic                IncPC,
   output logic                Cout,
   output logic                read,
   output logic                write,
   output logic [31:0]         c_ext,
   output logic [OP_W-1:0]     alu_op
);

   state_t          state_r;
   state_t          next_state_s;
   state_t          done_state_s;
   op_class_t       cls_s;
   strobe_t         sb_s;
   logic [OP_W-1:0] op_s;
   logic [OP_W-1:0] alu_op_s;
   logic            gra_s, grb_s, grc_s, rin_en_s, rout_en_s;
   logic            step_go_s;

   assign op_s         = ir[OP_MSB:OP_LSB];
   assign cls_s        = classify(op_s);
   assign done_state_s = stop ? S_HALT : S_T0;

`ifdef CTRL_SINGLE_STEP_EN
   logic step_q_r, step_prev_r;

   // Synchronise step and keep its previous value for rising-edge detection.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         step_q_r    <= 1'b0;
         step_prev_r <= 1'b0;
      end else begin
         step_q_r    <= step;
         step_prev_r <= step_q_r;
      end
   end

   assign step_go_s = step_q_r & ~step_prev_r;
`else
   assign step_go_s = 1'b1;
`endif

   // State register; clear aborts any instruction immediately.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_r <= S_RESET;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state and strobe decode.
   always_comb begin
      next_state_s = state_r;
      sb_s         = '0;
      alu_op_s     = ALU_ADD;
      gra_s        = 1'b0;
      grb_s        = 1'b0;
      grc_s        = 1'b0;
      rin_en_s     = 1'b0;
      rout_en_s    = 1'b0;
      case (state_r)
         S_RESET: next_state_s = S_T0;
         S_T0: begin
            sb_s.pc_out = 1'b1; sb_s.mar_in = 1'b1; sb_s.inc_pc = 1'b1; sb_s.z_in = 1'b1;
            if (step_go_s) next_state_s = S_T1;
            else           next_state_s = S_T0;
         end
         S_T1: begin
            sb_s.zlow_out = 1'b1; sb_s.pc_in = 1'b1; sb_s.rd = 1'b1; sb_s.mdr_in = 1'b1;
            if (mem_ready) next_state_s = S_T2;
            else           next_state_s = S_T1;
         end
         S_T2: begin
            sb_s.mdr_out = 1'b1; sb_s.ir_in = 1'b1;
            next_state_s = S_T3;
         end
         S_T3: begin
            case (cls_s)
               CL_ALU, CL_IMM, CL_LD, CL_LDI, CL_ST: begin
                  grb_s = 1'b1; rout_en_s = 1'b1; sb_s.y_in = 1'b1; next_state_s = S_T4;
               end
               CL_UNARY: begin
                  grb_s = 1'b1; rout_en_s = 1'b1; alu_op_s = op_s; sb_s.z_in = 1'b1;
                  next_state_s = S_T4;
               end
               CL_MULDIV: begin
                  gra_s = 1'b1; rout_en_s = 1'b1; sb_s.y_in = 1'b1; next_state_s = S_T4;
               end
               CL_HALT: next_state_s = S_HALT;
               default: next_state_s = done_state_s;
            endcase
         end
         S_T4: begin
            case (cls_s)
               CL_ALU: begin
                  grc_s = 1'b1; rout_en_s = 1'b1; alu_op_s = op_s; sb_s.z_in = 1'b1;
                  next_state_s = S_T5;
               end
               CL_IMM: begin
                  sb_s.c_out = 1'b1; alu_op_s = op_s; sb_s.z_in = 1'b1; next_state_s = S_T5;
               end
               CL_LD, CL_LDI, CL_ST: begin
                  sb_s.c_out = 1'b1; sb_s.z_in = 1'b1; next_state_s = S_T5;
               end
               CL_UNARY: begin
                  sb_s.zlow_out = 1'b1; gra_s = 1'b1; rin_en_s = 1'b1; next_state_s = done_state_s;
               end
               CL_MULDIV: begin
                  grb_s = 1'b1; rout_en_s = 1'b1; alu_op_s = op_s; sb_s.z_in = 1'b1;
                  next_state_s = S_T5;
               end
               default: next_state_s = done_state_s;
            endcase
         end
         S_T5: begin
            case (cls_s)
               CL_ALU, CL_IMM, CL_LDI: begin
                  sb_s.zlow_out = 1'b1; gra_s = 1'b1; rin_en_s = 1'b1; next_state_s = done_state_s;
               end
               CL_MULDIV: begin
                  sb_s.zlow_out = 1'b1; sb_s.lo_in = 1'b1; next_state_s = S_T6;
               end
               CL_LD, CL_ST: begin
                  sb_s.zlow_out = 1'b1; sb_s.mar_in = 1'b1; next_state_s = S_T6;
               end
               default: next_state_s = done_state_s;
            endcase
         end
         S_T6: begin
            case (cls_s)
               CL_MULDIV: begin
                  sb_s.zhigh_out = 1'b1; sb_s.hi_in = 1'b1; next_state_s = done_state_s;
               end
               CL_LD: begin
                  sb_s.rd = 1'b1; sb_s.mdr_in = 1'b1;
                  if (mem_ready) next_state_s = S_T7;
                  else           next_state_s = S_T6;
               end
               CL_ST: begin
                  gra_s = 1'b1; rout_en_s = 1'b1; sb_s.mdr_in = 1'b1; next_state_s = S_T7;
               end
               default: next_state_s = done_state_s;
            endcase
         end
         S_T7: begin
            case (cls_s)
               CL_LD: begin
                  sb_s.mdr_out = 1'b1; gra_s = 1'b1; rin_en_s = 1'b1; next_state_s = done_state_s;
               end
               CL_ST: begin
                  sb_s.wr = 1'b1;
                  if (mem_ready) next_state_s = done_state_s;
                  else           next_state_s = S_T7;
               end
               default: next_state_s = done_state_s;
            endcase
         end
         S_HALT:  next_state_s = S_HALT;
         default: next_state_s = S_RESET;
      endcase
   end

   reg_select_decode #(.NUM_REGS(NUM_REGS)) u_reg_select_decode (
      .ra      (ir[RA_LSB +: REG_W]),
      .rb      (ir[RB_LSB +: REG_W]),
      .rc      (ir[RC_LSB +: REG_W]),
      .gra     (gra_s),
      .grb     (grb_s),
      .grc     (grc_s),
      .rin_en  (rin_en_s),
      .rout_en (rout_en_s),
      .rin     (rin),
      .rout    (rout)
   );

   assign run      = (state_r != S_RESET) && (state_r != S_HALT);
   assign alu_op   = alu_op_s;
   assign c_ext    = {{13{ir[C_MSB]}}, ir[C_MSB:0]};
   assign HIin     = sb_s.hi_in;
   assign HIout    = sb_s.hi_out;
   assign LOin     = sb_s.lo_in;
   assign LOout    = sb_s.lo_out;
   assign Zin      = sb_s.z_in;
   assign Zhighout = sb_s.zhigh_out;
   assign Zlowout  = sb_s.zlow_out;
   assign Yin      = sb_s.y_in;
   assign MDRin    = sb_s.mdr_in;
   assign MDRout   = sb_s.mdr_out;
   assign MARin    = sb_s.mar_in;
   assign PCin     = sb_s.pc_in;
   assign PCout    = sb_s.pc_out;
   assign IRin     = sb_s.ir_in;
   assign IncPC    = sb_s.inc_pc;
   assign Cout     = sb_s.c_out;
   assign read     = sb_s.rd;
   assign write    = sb_s.wr;

endmodule
